// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } sched_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - two-requester round-robin arbiter with one-hot grant
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic [1:0] served,
  output logic [1:0] gnt
);

  // High means requester 1 wins the next tie; cleared so requester 0 wins first
  logic prio1;

  // Remember who was just served so the other side wins the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio1 <= 1'b0;
    end else if (update) begin
      prio1 <= served[0] & ~served[1];
    end
  end

  // Single requester wins outright; a tie goes to the favoured side
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = prio1 ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - packet-granular sharing of one UART byte transmitter
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int GAP_CYCLES = 500,
  parameter int GAP_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              s0_valid,
  input  logic [BYTE_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [BYTE_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic              sched_busy
);

  sched_state_e      state;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_q;
  logic              arb_update;
  logic [1:0]        arb_gnt;
  logic              owner_valid;
  logic              owner_last;
  logic [BYTE_W-1:0] owner_data;

  // Pointer moves on the same cycle the grant is dropped at the end of the gap
  assign arb_update = (state == ST_GAP) && (gap_cnt == '0);

  uart_rr_arb2 u_arb (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .req    ({s1_valid, s0_valid}),
    .update (arb_update),
    .served (grant),
    .gnt    (arb_gnt)
  );

  // Route the packet owner's stream; the non-owner is ignored entirely
  always_comb begin
    owner_valid = s0_valid;
    owner_last  = s0_last;
    owner_data  = s0_data;
    if (grant[1]) begin
      owner_valid = s1_valid;
      owner_last  = s1_last;
      owner_data  = s1_data;
    end
  end

  // Main sequencer: arbitrate, hand one byte per busy period, then idle gap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      last_q     <= 1'b0;
      grant      <= 2'b00;
      sched_busy <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            grant      <= arb_gnt;
            sched_busy <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (owner_valid) begin
            tx_data  <= owner_data;
            tx_start <= 1'b1;
            s0_ready <= grant[0];
            s1_ready <= grant[1];
            last_q   <= owner_last;
            state    <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          // Busy seen while our own start pulse is still out is stale
          if (tx_busy && !tx_start) begin
            state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              state   <= ST_GAP;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            grant      <= 2'b00;
            sched_busy <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int G = 12;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       sched_busy;

  uart_tx_scheduler #(.GAP_CYCLES(G), .GAP_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .s0_valid   (s0_valid),
    .s0_data    (s0_data),
    .s0_last    (s0_last),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_data    (s1_data),
    .s1_last    (s1_last),
    .s1_ready   (s1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .sched_busy (sched_busy)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  // Reference state: per-requester byte queues {last,data}, tie favour, packet log
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         pkt_seq[$];
  logic [1:0] vh[8];
  int  cyc = 0;
  int  tx_count = 0;
  int  favour = 0;
  int  cur_owner = -1;
  bit  in_pkt = 0;
  bit  relaxed = 0;
  bit  hold0 = 0;
  int  last_fall = -1;
  int  busy_rise_at = -1;
  int  busy_fall_at = -1;
  int  gap_dist = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_sources();
    s0_valid = (q0.size() > 0) && !hold0;
    {s0_last, s0_data} = (q0.size() > 0) ? q0[0] : 9'h000;
    s1_valid = (q1.size() > 0);
    {s1_last, s1_data} = (q1.size() > 0) ? q1[0] : 9'h000;
  endtask

  function automatic int seq_code(input int start);
    int c = 0;
    for (int i = start; i < pkt_seq.size(); i++) c |= pkt_seq[i] << (i - start);
    return c;
  endfunction

  task automatic step();
    logic [8:0] b;
    logic [1:0] v;
    int owner;
    int expw;
    @(negedge sys_clk);
    cyc++;
    if (tx_start === 1'b1) begin
      tx_count++;
      chk("start_while_busy", tx_busy, 0);
      chk("ready_count", int'(s0_ready) + int'(s1_ready), 1);
      owner = s1_ready ? 1 : 0;
      b = 9'h000;
      chk("queue_nonempty", ((owner == 1) ? q1.size() : q0.size()) > 0, 1);
      if (owner == 1 && q1.size() > 0) b = q1.pop_front();
      if (owner == 0 && q0.size() > 0) b = q0.pop_front();
      chk("tx_data", tx_data, b[7:0]);
      chk("grant_owner", grant, (owner == 1) ? 2'b10 : 2'b01);
      if (!in_pkt) begin
        v = vh[(cyc - 2) & 7];
        expw = (v == 2'b11) ? favour : (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : -1;
        chk("arb_winner", owner, expw);
        if (last_fall >= 0) begin
          gap_dist = cyc - last_fall;
          chk("gap_min", gap_dist >= G + 3, 1);
        end
        pkt_seq.push_back(owner);
      end else begin
        chk("pkt_owner", owner, cur_owner);
        if (!relaxed) chk("b2b_latency", cyc - last_fall, 2);
      end
      cur_owner = owner;
      in_pkt = !b[8];
      if (b[8]) favour = 1 - owner;
      busy_rise_at = cyc + 1 + $urandom_range(0, 2);
      busy_fall_at = busy_rise_at + $urandom_range(3, 10);
    end else begin
      chk("ready_no_start", {s1_ready, s0_ready}, 2'b00);
    end
    if (cyc == busy_rise_at) tx_busy = 1'b1;
    if (cyc == busy_fall_at) begin
      tx_busy = 1'b0;
      last_fall = cyc;
    end
    drive_sources();
    vh[cyc & 7] = {s1_valid, s0_valid};
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    q0.delete();
    q1.delete();
    hold0 = 0;
    favour = 0;
    in_pkt = 0;
    last_fall = -1;
    busy_rise_at = -1;
    busy_fall_at = -1;
    tx_busy = 1'b0;
    for (int i = 0; i < 8; i++) vh[i] = 2'b00;
    drive_sources();
  endtask

  task automatic release_reset();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && !(q0.size() == 0 && q1.size() == 0 && !sched_busy && !tx_busy && !in_pkt)) begin
      step();
      n++;
    end
    chk("idle_timeout", n < max, 1);
  endtask

  task automatic wait_start(input int base, input int max);
    int n = 0;
    while (n < max && tx_count <= base) begin
      step();
      n++;
    end
    chk("start_timeout", n < max, 1);
  endtask

  task automatic push_pkt(input int r, input int len);
    logic [8:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
      if (r == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  initial begin
    int n;
    int base;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    apply_reset();
    step();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 2'b00);
    chk("rst_sched_busy", sched_busy, 0);
    release_reset();

    // Single byte from s0, grant held through the gap
    base = tx_count;
    q0.push_back(9'h10F);
    wait_start(base, 20);
    n = 0;
    while (n < 50 && (tx_busy || cyc <= busy_fall_at)) begin
      step();
      n++;
    end
    repeat (G / 2) step();
    chk("single_gap_grant", grant, 2'b01);
    chk("single_gap_busy", sched_busy, 1);
    wait_idle(200);
    chk("single_count", tx_count - base, 1);
    chk("single_grant_end", grant, 2'b00);

    // Contention straight out of reset: s0 first, s1 after a full gap
    apply_reset();
    q0.push_back(9'h10F);
    q1.push_back(9'h1F0);
    drive_sources();
    n = pkt_seq.size();
    release_reset();
    wait_idle(300);
    chk("cont_pkts", pkt_seq.size() - n, 2);
    chk("cont_order", seq_code(n), 2);
    chk("cont_gap", gap_dist, G + 3);

    // Multi-byte packet from s1; s0 arrives mid-packet and waits
    apply_reset();
    q1.push_back(9'h0A1);
    q1.push_back(9'h0A2);
    q1.push_back(9'h1A3);
    drive_sources();
    n = pkt_seq.size();
    base = tx_count;
    release_reset();
    wait_start(base, 20);
    q0.push_back(9'h15A);
    drive_sources();
    wait_idle(400);
    chk("multi_starts", tx_count - base, 4);
    chk("multi_pkts", pkt_seq.size() - n, 2);
    chk("multi_order", seq_code(n), 2'b01);

    // Fairness: s0 always has a packet, s1 has one
    apply_reset();
    q0.push_back(9'h111);
    q0.push_back(9'h122);
    q0.push_back(9'h133);
    q1.push_back(9'h1A5);
    drive_sources();
    n = pkt_seq.size();
    release_reset();
    wait_idle(500);
    chk("fair_pkts", pkt_seq.size() - n, 4);
    chk("fair_order", seq_code(n), 4'b0010);

    // Valid drop mid-packet: grant held, nothing sent, s1 kept waiting
    apply_reset();
    relaxed = 1;
    q0.push_back(9'h0B1);
    q0.push_back(9'h1B2);
    q1.push_back(9'h1C1);
    drive_sources();
    n = pkt_seq.size();
    base = tx_count;
    release_reset();
    wait_start(base, 20);
    hold0 = 1;
    drive_sources();
    base = tx_count;
    repeat (100) step();
    chk("drop_starts", tx_count, base);
    chk("drop_grant", grant, 2'b01);
    chk("drop_busy", sched_busy, 1);
    hold0 = 0;
    wait_idle(400);
    chk("drop_order", seq_code(n), 2'b10);
    relaxed = 0;

    // Reset while waiting for the transmitter to finish
    apply_reset();
    q0.push_back(9'h155);
    drive_sources();
    release_reset();
    n = 0;
    while (n < 30 && !tx_busy) begin
      step();
      n++;
    end
    chk("wlo_busy_timeout", n < 30, 1);
    step();
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("wlo_rst_tx_start", tx_start, 0);
    chk("wlo_rst_tx_data", tx_data, 8'h00);
    chk("wlo_rst_grant", grant, 2'b00);
    chk("wlo_rst_sched_busy", sched_busy, 0);
    apply_reset();
    q1.push_back(9'h1C3);
    drive_sources();
    n = pkt_seq.size();
    release_reset();
    wait_idle(200);
    chk("wlo_after_pkts", pkt_seq.size() - n, 1);
    chk("wlo_after_owner", seq_code(n), 1);

    // Randomised traffic
    apply_reset();
    release_reset();
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) push_pkt(0, $urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) push_pkt(1, $urandom_range(1, 3));
        repeat ($urandom_range(0, 30)) step();
      end
      wait_idle(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
